// File: rtl/axi_slv_pkg.sv
// Shared types and AXI encodings for the single-port SRAM AXI3 responder.
package axi_slv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    R_ISSUE,
    R_WAIT,
    R_DATA,
    W_DATA,
    W_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  // Decode error outranks a slave error when both apply to a burst.
  function automatic logic [1:0] resp_code(input logic err, input logic oor);
    if (oor)
      return RESP_DECERR;
    else if (err)
      return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_slv_addr_gen.sv
// Burst word-address and beat counter; AXI_SLV_OOR_CHECK_EN adds top-of-memory crossing detection.
module axi_slv_addr_gen
  import axi_slv_pkg::*;
#(
  parameter int unsigned MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [MEM_AW-1:0] load_addr,
  input  logic [3:0]        load_len,
  input  logic [1:0]        load_burst,
  input  logic              load_oor,
  output logic [MEM_AW-1:0] addr,
  output logic [3:0]        count,
  output logic              last,
  output logic              oor
);

  logic [3:0] len;
  logic [1:0] burst;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr  <= '0;
      count <= '0;
      len   <= '0;
      burst <= '0;
      oor   <= 1'b0;
    end else if (load) begin
      addr  <= load_addr;
      count <= '0;
      len   <= load_len;
      burst <= load_burst;
      oor   <= load_oor;
    end else if (advance) begin
      count <= count + 4'd1;
      if (burst == BURST_INCR)
        addr <= addr + MEM_AW'(1);
`ifdef AXI_SLV_OOR_CHECK_EN
      // Stepping past the last word poisons this and every later beat.
      if (burst == BURST_INCR && addr == '1)
        oor <= 1'b1;
`endif
    end
  end

  assign last = (count == len);

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave port terminating onto a single-port synchronous SRAM, one burst at a time.
// Define AXI_SLV_OOR_CHECK_EN to return DECERR for addresses beyond the SRAM.
module axi_sram_slave
  import axi_slv_pkg::*;
#(
  parameter int unsigned IDS_W  = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MEM_AW = 14,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [IDS_W-1:0]  AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [IDS_W-1:0]  BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [IDS_W-1:0]  ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [IDS_W-1:0]  RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              sram_cs,
  output logic [STRB_W-1:0] sram_we,
  output logic [MEM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  state_t            state, state_nxt;
  logic              prio;
  logic [IDS_W-1:0]  id_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              ar_sel, aw_sel, load, advance, w_mismatch;
  logic [MEM_AW-1:0] ld_addr;
  logic [3:0]        ld_len;
  logic [2:0]        ld_size;
  logic [1:0]        ld_burst;
  logic [IDS_W-1:0]  ld_id;
  logic              ld_err, ld_oor;
  logic              last, oor, bad;
  logic [3:0]        beat_count;
  logic              unused_bits;

  assign ar_sel = ARESETn && (state == IDLE) && ARVALID && (!AWVALID || !prio);
  assign aw_sel = ARESETn && (state == IDLE) && AWVALID && (!ARVALID || prio);

  assign ld_addr  = ar_sel ? ARADDR[MEM_AW+1:2] : AWADDR[MEM_AW+1:2];
  assign ld_len   = ar_sel ? ARLEN   : AWLEN;
  assign ld_size  = ar_sel ? ARSIZE  : AWSIZE;
  assign ld_burst = ar_sel ? ARBURST : AWBURST;
  assign ld_id    = ar_sel ? ARID    : AWID;
  assign ld_err   = (ld_size != SIZE_WORD) ||
                    (ld_burst != BURST_FIXED && ld_burst != BURST_INCR);
`ifdef AXI_SLV_OOR_CHECK_EN
  assign ld_oor = ar_sel ? (|ARADDR[ADDR_W-1:MEM_AW+2]) : (|AWADDR[ADDR_W-1:MEM_AW+2]);
`else
  assign ld_oor = 1'b0;
`endif

  assign unused_bits = ^{AWADDR[ADDR_W-1:MEM_AW+2], AWADDR[1:0],
                         ARADDR[ADDR_W-1:MEM_AW+2], ARADDR[1:0], beat_count};

  axi_slv_addr_gen #(
    .MEM_AW(MEM_AW)
  ) u_addr_gen (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .load      (load),
    .advance   (advance),
    .load_addr (ld_addr),
    .load_len  (ld_len),
    .load_burst(ld_burst),
    .load_oor  (ld_oor),
    .addr      (sram_addr),
    .count     (beat_count),
    .last      (last),
    .oor       (oor)
  );

  assign bad   = err_q || oor;
  assign RID   = id_q;
  assign BID   = id_q;
  assign RDATA = rdata_q;
  assign RRESP = resp_code(err_q, oor);
  assign BRESP = resp_code(err_q, oor);

  // Everything combinational is held low while ARESETn is asserted so an
  // in-flight write beat cannot reach the SRAM on the reset edge.
  always_comb begin
    state_nxt  = state;
    AWREADY    = 1'b0;
    ARREADY    = 1'b0;
    WREADY     = 1'b0;
    BVALID     = 1'b0;
    RVALID     = 1'b0;
    RLAST      = 1'b0;
    sram_cs    = 1'b0;
    sram_we    = '0;
    sram_din   = '0;
    load       = 1'b0;
    advance    = 1'b0;
    w_mismatch = 1'b0;
    if (ARESETn) begin
      case (state)
        IDLE: begin
          ARREADY = ar_sel;
          AWREADY = aw_sel;
          load    = ar_sel || aw_sel;
          if (ar_sel)
            state_nxt = R_ISSUE;
          else if (aw_sel)
            state_nxt = W_DATA;
        end
        R_ISSUE: begin
          sram_cs   = !bad;
          state_nxt = R_WAIT;
        end
        R_WAIT: state_nxt = R_DATA;
        R_DATA: begin
          RVALID = 1'b1;
          RLAST  = last;
          if (RREADY) begin
            if (last) begin
              state_nxt = IDLE;
            end else begin
              advance   = 1'b1;
              state_nxt = R_ISSUE;
            end
          end
        end
        W_DATA: begin
          WREADY = 1'b1;
          if (WVALID) begin
            sram_cs  = !bad;
            sram_we  = bad ? '0 : WSTRB;
            sram_din = WDATA;
            if (WLAST || last) begin
              w_mismatch = (WLAST != last);
              state_nxt  = W_RESP;
            end else begin
              advance = 1'b1;
            end
          end
        end
        W_RESP: begin
          BVALID = 1'b1;
          if (BREADY)
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state   <= IDLE;
      prio    <= 1'b0;
      id_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        prio  <= ~prio;
        id_q  <= ld_id;
        err_q <= ld_err;
      end
      if (w_mismatch)
        err_q <= 1'b1;
      if (state == R_WAIT)
        rdata_q <= bad ? '0 : sram_dout;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave with a behavioural SRAM model.
module tb_axi_sram_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [7:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        sram_cs;
  logic [3:0]  sram_we;
  logic [13:0] sram_addr;
  logic [31:0] sram_din, sram_dout;

  always #5 ACLK = ~ACLK;

  axi_sram_slave #(
    .IDS_W(8), .ADDR_W(32), .DATA_W(32), .MEM_AW(14)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  logic [31:0] mem [0:16383];
  int unsigned cs_count = 0;
  int unsigned we_count = 0;

  always @(posedge ACLK) begin
    if (sram_cs) begin
      cs_count <= cs_count + 1;
      if (|sram_we)
        we_count <= we_count + 1;
      for (int b = 0; b < 4; b++)
        if (sram_we[b])
          mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      sram_dout <= mem[sram_addr];
    end
  end

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_d [16];
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];
  int unsigned we0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_addr(input bit rd, input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    if (rd) begin
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    end else begin
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    end
    @(negedge ACLK);
    while (!(rd ? ARREADY : AWREADY) && t < 50) begin
      tick();
      @(negedge ACLK);
      t++;
    end
    check(rd ? "ar_accept" : "aw_accept", rd ? ARREADY : AWREADY, 1'b1);
    tick();
    if (rd) ARVALID = 1'b0;
    else    AWVALID = 1'b0;
  endtask

  task automatic send_w(input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      WDATA = wdat[i]; WSTRB = wstb[i]; WLAST = (i == last_at); WVALID = 1'b1;
      @(negedge ACLK);
      while (!WREADY && t < 50) begin
        tick();
        @(negedge ACLK);
        t++;
      end
      check("w_accept", WREADY, 1'b1);
      tick();
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
  endtask

  task automatic get_b(input logic [7:0] id, input logic [1:0] resp);
    int t = 0;
    BREADY = 1'b1;
    @(negedge ACLK);
    while (!BVALID && t < 50) begin
      tick();
      @(negedge ACLK);
      t++;
    end
    check("bvalid", BVALID, 1'b1);
    check("bid", BID, id);
    check("bresp", BRESP, resp);
    tick();
    BREADY = 1'b0;
  endtask

  task automatic get_r(input int n, input logic [7:0] id, input logic [1:0] resp, input int stall);
    int beat = 0;
    int t = 0;
    int held = 0;
    int unsigned cs0 = 0;
    while (beat < n && t < 200) begin
      RREADY = !(beat == stall && held < 5);
      @(negedge ACLK);
      if (RVALID) begin
        if (RREADY) begin
          check("rdata", RDATA, exp_d[beat]);
          check("rlast", RLAST, beat == n - 1);
          check("rid", RID, id);
          check("rresp", RRESP, resp);
          beat++;
        end else begin
          if (held == 0) cs0 = cs_count;
          check("r_hold", {RVALID, RLAST, RDATA}, {1'b1, beat == n - 1, exp_d[beat]});
          held++;
          if (held == 5) check("r_hold_cs", cs_count - cs0, 0);
        end
      end
      tick();
      t++;
    end
    RREADY = 1'b0;
    check("r_beats", beat, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    mem[16] = 32'hA0A0_0001;
    mem[17] = 32'hA0A0_0002;

    repeat (3) tick();
    @(negedge ACLK);
    check("reset_outs", {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, sram_cs, sram_we,
                         BID, RID, RDATA, BRESP, RRESP}, '0);
    check("reset_sram", {sram_addr, sram_din}, '0);
    ARESETn = 1'b1;
    tick();

    // Simultaneous AR/AW: read wins first, stalled AW wins the next collision.
    AWID = 8'h21; AWADDR = 32'h200; AWLEN = 4'd0; AWSIZE = 3'b010; AWBURST = 2'b01; AWVALID = 1'b1;
    ARID = 8'h31; ARADDR = 32'h40;  ARLEN = 4'd0; ARSIZE = 3'b010; ARBURST = 2'b01; ARVALID = 1'b1;
    @(negedge ACLK);
    check("sim1_ready", {ARREADY, AWREADY}, 2'b10);
    tick();
    ARVALID = 1'b0;
    exp_d[0] = 32'hA0A0_0001;
    get_r(1, 8'h31, 2'b00, -1);
    ARID = 8'h32; ARADDR = 32'h44; ARVALID = 1'b1;
    @(negedge ACLK);
    check("sim2_ready", {ARREADY, AWREADY}, 2'b01);
    tick();
    AWVALID = 1'b0;
    wdat[0] = 32'h5A5A_5A5A; wstb[0] = 4'hF;
    send_w(1, 0);
    get_b(8'h21, 2'b00);
    send_addr(1'b1, 8'h32, 32'h44, 4'd0, 3'b010, 2'b01);
    exp_d[0] = 32'hA0A0_0002;
    get_r(1, 8'h32, 2'b00, -1);

    // Four-beat INCR write and read-back.
    for (int i = 0; i < 4; i++) begin
      wdat[i] = i + 1; wstb[i] = 4'hF; exp_d[i] = i + 1;
    end
    send_addr(1'b0, 8'h12, 32'h40, 4'd3, 3'b010, 2'b01);
    send_w(4, 3);
    get_b(8'h12, 2'b00);
    send_addr(1'b1, 8'h12, 32'h40, 4'd3, 3'b010, 2'b01);
    get_r(4, 8'h12, 2'b00, -1);

    // Byte strobes.
    wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'hF;
    send_addr(1'b0, 8'h13, 32'h100, 4'd0, 3'b010, 2'b01);
    send_w(1, 0);
    get_b(8'h13, 2'b00);
    wdat[0] = 32'h1122_3344; wstb[0] = 4'b0101;
    send_addr(1'b0, 8'h14, 32'h100, 4'd0, 3'b010, 2'b01);
    send_w(1, 0);
    get_b(8'h14, 2'b00);
    exp_d[0] = 32'hFF22_FF44;
    send_addr(1'b1, 8'h15, 32'h100, 4'd0, 3'b010, 2'b01);
    get_r(1, 8'h15, 2'b00, -1);

    // RREADY held low for 5 cycles on beat 2.
    for (int i = 0; i < 4; i++) exp_d[i] = i + 1;
    send_addr(1'b1, 8'h05, 32'h40, 4'd3, 3'b010, 2'b01);
    get_r(4, 8'h05, 2'b00, 1);

    // Bad AWSIZE: SLVERR, no SRAM write.
    we0 = we_count;
    wdat[0] = 32'hAAAA_AAAA; wdat[1] = 32'hBBBB_BBBB; wstb[0] = 4'hF; wstb[1] = 4'hF;
    send_addr(1'b0, 8'h40, 32'h300, 4'd1, 3'b001, 2'b01);
    send_w(2, 1);
    get_b(8'h40, 2'b10);
    check("err_no_we", we_count - we0, 0);

    // Reserved burst type on read: SLVERR with zero data.
    exp_d[0] = 32'h0;
    send_addr(1'b1, 8'h41, 32'h40, 4'd0, 3'b010, 2'b10);
    get_r(1, 8'h41, 2'b10, -1);

    // Early WLAST (LEN=3, WLAST on beat 2), then confirm the slave is idle again.
    send_addr(1'b0, 8'h42, 32'h400, 4'd3, 3'b010, 2'b01);
    send_w(2, 1);
    get_b(8'h42, 2'b10);
    exp_d[0] = 32'h1;
    send_addr(1'b1, 8'h43, 32'h40, 4'd0, 3'b010, 2'b01);
    get_r(1, 8'h43, 2'b00, -1);

    // Missing WLAST on LEN=0: burst closes on the count anyway.
    send_addr(1'b0, 8'h44, 32'h410, 4'd0, 3'b010, 2'b01);
    send_w(1, -1);
    get_b(8'h44, 2'b10);

    // FIXED burst keeps overwriting one word.
    wdat[0] = 32'h1111_0000; wdat[1] = 32'h2222_0000;
    send_addr(1'b0, 8'h50, 32'h500, 4'd1, 3'b010, 2'b00);
    send_w(2, 1);
    get_b(8'h50, 2'b00);
    exp_d[0] = 32'h2222_0000; exp_d[1] = 32'h0;
    send_addr(1'b1, 8'h51, 32'h500, 4'd1, 3'b010, 2'b01);
    get_r(2, 8'h51, 2'b00, -1);

    // INCR wraps from the top word to word 0.
    wdat[0] = 32'h3333_3333; wdat[1] = 32'h4444_4444;
    send_addr(1'b0, 8'h52, 32'hFFFC, 4'd1, 3'b010, 2'b01);
    send_w(2, 1);
    get_b(8'h52, 2'b00);
    exp_d[0] = 32'h3333_3333; exp_d[1] = 32'h4444_4444;
    send_addr(1'b1, 8'h53, 32'hFFFC, 4'd1, 3'b010, 2'b01);
    get_r(2, 8'h53, 2'b00, -1);
    exp_d[0] = 32'h4444_4444;
    send_addr(1'b1, 8'h54, 32'h0, 4'd0, 3'b010, 2'b01);
    get_r(1, 8'h54, 2'b00, -1);

    // Reset in the middle of a write burst.
    send_addr(1'b0, 8'h60, 32'h600, 4'd3, 3'b010, 2'b01);
    WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; WVALID = 1'b1;
    ARESETn = 1'b0;
    tick();
    we0 = we_count;
    @(negedge ACLK);
    check("midrst_outs", {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, sram_cs, sram_we,
                          BID, RID, RDATA, BRESP, RRESP}, '0);
    tick();
    check("midrst_no_we", we_count - we0, 0);
    WVALID = 1'b0;
    ARESETn = 1'b1;
    tick();
    wdat[0] = 32'h7777_7777; wstb[0] = 4'hF;
    send_addr(1'b0, 8'h61, 32'h600, 4'd0, 3'b010, 2'b01);
    send_w(1, 0);
    get_b(8'h61, 2'b00);
    exp_d[0] = 32'h7777_7777;
    send_addr(1'b1, 8'h62, 32'h600, 4'd0, 3'b010, 2'b01);
    get_r(1, 8'h62, 2'b00, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 responder that terminates one interconnect slave port (S0/S1 side) and drives a single-port, word-wide synchronous SRAM.
- Accepts one read or write burst at a time (FIXED/INCR, up to 16 beats) and returns R beats or a single B response with the ID echoed.
- Sits between the AXI interconnect slave-side outputs and the memory macro.

Parameters:
- IDS_W, 8, AXI slave-side ID width (matches AXI_IDS_BITS)
- ADDR_W, 32, AXI address width
- DATA_W, 32, data width; STRB_W = DATA_W/8
- MEM_AW, 14, SRAM word-address width (depth = 2**MEM_AW words)

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  IDS_W/ADDR_W/4/3/2/1  write address
- AWREADY  out  1
- WDATA/WSTRB/WLAST/WVALID  in  DATA_W/STRB_W/1/1  write data
- WREADY  out  1
- BID/BRESP/BVALID  out  IDS_W/2/1  write response; BREADY  in  1
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  IDS_W/ADDR_W/4/3/2/1  read address
- ARREADY  out  1
- RID/RDATA/RRESP/RLAST/RVALID  out  IDS_W/DATA_W/2/1/1  read data; RREADY  in  1
- sram_cs/sram_we  out  1/STRB_W  chip select, per-byte write enable
- sram_addr/sram_din  out  MEM_AW/DATA_W
- sram_dout  in  DATA_W  valid the cycle after a read select
- Interface: one clock, ACLK; reset is ARESETn, synchronous and active-low.

Behaviour:
- Reset (ARESETn=0 at the ACLK edge): state=IDLE. All outputs are 0, including the READY, VALID, sram_cs and sram_we signals. The priority bit is set to 0, which favours read.
- FSM states: IDLE, R_ISSUE, R_WAIT, R_DATA, W_DATA, W_RESP.
- IDLE:
  - AWREADY and ARREADY are combinational in IDLE only. ARREADY=ARVALID&&(!AWVALID||prio==0). AWREADY=AWVALID&&(!ARVALID||prio==1).
  - On handshake, register ID, word address (addr[MEM_AW+1:2]), LEN, BURST and error flag. Clear the beat counter and toggle prio.
  - AR goes to R_ISSUE; AW goes to W_DATA.
- Error flag: set when SIZE!=3'b010 or BURST is not FIXED(00)/INCR(01). An errored burst performs no SRAM access, but its beats and response complete normally with resp=SLVERR(2'b10).
- Read path:
  - R_ISSUE: sram_cs=1, sram_we=0. Go to R_WAIT.
  - R_WAIT: register sram_dout into RDATA at the edge. Go to R_DATA.
  - R_DATA: RVALID=1. RID, RDATA, RRESP and RLAST are held stable while RREADY=0. RLAST=(count==LEN).
  - On the RVALID&&RREADY handshake: if last, go to IDLE; else advance the address, count+1, and go to R_ISSUE.
  - Latency is 3 cycles per beat. An errored read returns RDATA=0 and skips the SRAM.
- Write path:
  - W_DATA: WREADY=1. On WVALID (the same cycle), sram_cs=1, sram_we=WSTRB (0 if errored), sram_din=WDATA and sram_addr=current address.
  - Advance the address and count on each beat.
  - Burst ends on WLAST, or on count==LEN. WLAST and count disagreeing sets SLVERR. Beats after the LEN-th are not accepted: go to W_RESP.
- W_RESP: BVALID=1 with BID and BRESP held until BREADY, then go to IDLE. BRESP is OKAY(00) unless an error is set.
- Address advance: FIXED holds the address. INCR adds 1 word, wrapping modulo 2**MEM_AW.
- LEN=0: single beat, and RLAST asserts on the first beat.
- Simultaneous AR and AW in IDLE: exactly one is accepted, chosen by prio; the other stays stalled.
- Mid-burst reset: abandon the burst immediately; no further SRAM write occurs after the reset edge.

Optional Feature:
- Macro AXI_SLV_OOR_CHECK_EN.
- Defined: a start address with ADDR_W bits above MEM_AW+1 nonzero is flagged out-of-range.
  - The whole burst completes without SRAM access, with resp=DECERR(2'b11) and RDATA=0.
  - An INCR burst that crosses the top of memory gives DECERR on the crossing beat and every beat after it.
- Undefined: upper address bits are ignored and addresses wrap modulo depth.

Decomposition:
- Package axi_slv_pkg holds:
  - the state enum
  - RESP constants OKAY/SLVERR/DECERR
  - BURST constants FIXED/INCR
  - SIZE_WORD=3'b010
- Sub-module axi_slv_addr_gen: registered burst address and beat counter, with load/advance inputs and outputs addr, count, last and oor.

Test Plan:
- Write then read back: AW id=8'h12, addr=0x40, LEN=3, INCR, data 1..4 with strobe F, then an AR of the same burst. Expect BRESP=00, BID=12, four R beats 1..4, RLAST only on beat 4, RID=12.
- Byte strobes: preload 0xFFFFFFFF, write 0x11223344 with WSTRB=4'b0101, read back. Expect 0xFF22FF44.
- Simultaneous AR and AW in IDLE after reset. Expect AR accepted first, then AW; next simultaneous pair accepts AW first.
- RREADY backpressure: hold RREADY=0 for 5 cycles on beat 2. Expect RVALID, RDATA and RLAST stable throughout, with no extra sram_cs pulse.
- Error and early WLAST: AWSIZE=3'b001 gives BRESP=10 and sram_we never asserted. LEN=3 with WLAST on beat 2 gives BRESP=10 and a return to IDLE.
- Reset mid-burst: ARESETn=0 during W_DATA beat 1. Expect all outputs 0 on the next cycle, sram_we=0, and a new burst accepted after release.
